uart_frame_assembler: RTL and testbench
=======================================

# uart_frame_assembler

Sits directly downstream of the UART receiver. Consumes its byte stream (`data_out`/`valid`) and finds framed packets. Packs each packet's payload bytes little-endian into `8*WORD_BYTES`-bit words and buffers them in a small FIFO with a valid/ready output toward the network's weight/input loaders. Validates each packet with an XOR checksum and reports per-frame completion or error.

## Interface
- `WORD_BYTES`, default 2: bytes per output word, range 1..4.
- `FIFO_DEPTH`, default 8: output FIFO entries, power of two, at least 2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-low reset. The block is in reset while `reset == 0` at a clock edge.
- `in_data`  in  8: byte from the UART receiver.
- `in_valid`  in  1: UART receiver valid. Treated as a level.
- `out_data`  out  8*WORD_BYTES: FIFO head word.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the head word when `out_valid && out_ready`.
- `frame_done`  out  1: one-cycle pulse when a frame ends with a good checksum and no overflow.
- `frame_err`  out  1: one-cycle pulse when a frame is bad (bad checksum, LEN=0, or overflow).
- `overflow`  out  1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- `busy`  out  1: high when the FSM is not in IDLE.

## Operation
- **Byte acceptance**
  - A byte is accepted only on a 0→1 transition of `in_valid`, using a registered previous value.
  - Holding `in_valid` high for several cycles yields exactly one byte.
- **Frame format**
  - SYNC, then LEN (word count, 1..255), then LEN×WORD_BYTES payload bytes, then CHK.
  - CHK = XOR of LEN and every payload byte.
- **FSM states: IDLE, LEN, PAYLOAD, CHECK**
  - IDLE: a byte equal to SYNC_BYTE → LEN. Any other byte is discarded.
  - LEN: a byte of 0 → pulse `frame_err`, → IDLE. A non-zero byte → load word counter, seed checksum with LEN, → PAYLOAD.
  - PAYLOAD: each byte shifts into the word assembler, with the first byte landing in bits [7:0], and is XORed into the checksum. After WORD_BYTES bytes the word is pushed into the FIFO and the word counter is decremented. After the last word → CHECK.
  - CHECK: CHK matches and the sticky overflow flag is clear → `frame_done`. Otherwise → `frame_err`. Either way → IDLE and the sticky flag clears.
- **Delivery**
  - Words are delivered as they complete. They are not retracted on error.
  - The consumer discards the frame when it sees `frame_err`.
- **FIFO**
  - Show-ahead: `out_data` shows the head whenever `out_valid` is high.
  - Push while full without a pop in the same cycle: the word is dropped, `overflow` pulses and the sticky overflow flag is set.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a count of $clog2(FIFO_DEPTH)+1 bits.
- **Reset values**
  - FSM in IDLE.
  - FIFO empty, so `out_valid` = 0.
  - `out_data` = 0.
  - `frame_done`, `frame_err`, `overflow`, `busy` all 0.
  - Edge-detect register = 1, so a byte whose valid is already high during reset is not taken.
  - Word assembler, counters and checksum all 0.
- **Reset mid-frame:** the partial word and frame are dropped, the FIFO is flushed, and no pulse is emitted.

## Timing
- Edge detection takes one cycle. The byte is processed at the edge after `in_valid` is first seen high.
- The last byte of a word is processed at edge N. The FIFO write happens at edge N. `out_valid` is high after edge N, so the word is visible in cycle N+1.
- `frame_done` and `frame_err` are high for the single cycle after the edge that processes CHK, or LEN=0.
- A FIFO pop takes effect at the edge where `out_valid && out_ready`. The next word appears in the following cycle.
- `out_ready` has no combinational path to any output other than through registered FIFO state.
- Minimum byte spacing is 2 cycles. UART byte spacing far exceeds this.

## Test plan
- **Good frame:** bytes A5 02 34 12 78 56 0A, `out_ready` = 1 → `out_data` 16'h1234 then 16'h5678, then one `frame_done` pulse, no `frame_err`.
- **Bad checksum:** same frame with CHK = 0B → both words are still output, then `frame_err` pulse, no `frame_done`.
- **Noise before sync, LEN=0:** bytes 00 FF 5A → no output, `busy` stays 0. Bytes A5 00 → `frame_err` pulse, FSM back to IDLE. A following good frame is decoded correctly.
- **Backpressure/overflow:** `out_ready` = 0, FIFO_DEPTH = 8, LEN = 10 with a correct CHK → 8 words held, 2 `overflow` pulses, `frame_err` at CHK. Raising `out_ready` then drains exactly the first 8 words in order.
- **Level valid and simultaneous push/pop:** `in_valid` held high 5 cycles per byte → each byte counted once. With the FIFO full and `out_ready` = 1 on the word-complete cycle → no overflow, count unchanged.
- **Reset mid-frame:** drive `reset` = 0 for 1 cycle after the 3rd payload byte → FIFO empty, all outputs 0, no pulses. The next good frame decodes normally.

Source files
------------

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler
// Finds SYNC/LEN/payload/CHK frames in the UART receiver byte stream. Payload
// bytes are packed little-endian into 8*WORD_BYTES-bit words and queued in a
// show-ahead FIFO. Each frame is validated with an XOR checksum.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low reset
//   in_data    - byte from the UART receiver
//   in_valid   - receiver valid (level; a byte is taken on its rising edge)
//   out_data   - FIFO head word (0 while the FIFO is empty)
//   out_valid  - FIFO non-empty
//   out_ready  - consumer accepts the head word when out_valid && out_ready
//   frame_done - one-cycle pulse: frame ended with good checksum, no overflow
//   frame_err  - one-cycle pulse: bad checksum, LEN=0 or overflow in frame
//   overflow   - one-cycle pulse: completed word dropped, FIFO full
//   busy       - FSM is not in IDLE
module uart_frame_assembler #(
   parameter int unsigned WORD_BYTES = 2,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic                    overflow,
   output logic                    busy
);

   localparam int unsigned WW = 8 * WORD_BYTES;
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK} state_t;

   state_t          state;
   logic            valid_q;
   logic [WW-1:0]   asm_q;
   logic [BW-1:0]   byte_idx;
   logic [7:0]      word_cnt;
   logic [7:0]      chk_q;
   logic            ovf_sticky;

   logic [WW-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            byte_stb;
   logic [WW-1:0]   word_c;
   logic            push_c;
   logic            pop_c;
   logic            full_c;
   logic            push_ok_c;

   assign out_valid = (count != '0);
   // Gate the head so out_data reads 0 when nothing is queued.
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // Byte strobe, word being assembled with the current byte, FIFO handshake.
   always_comb begin
      byte_stb = in_valid & ~valid_q;
      word_c   = asm_q;
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
         if (BW'(i) == byte_idx) word_c[8*i +: 8] = in_data;
      end
      push_c    = byte_stb && (state == S_PAYLOAD) && (byte_idx == LAST_BYTE);
      pop_c     = out_valid && out_ready;
      full_c    = (count == CW'(FIFO_DEPTH));
      push_ok_c = push_c && (!full_c || pop_c);
   end

   // FIFO storage; contents are don't-care while count says empty.
   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_ptr] <= word_c;
   end

   // Frame FSM, word assembler and FIFO bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         valid_q    <= 1'b1;
         asm_q      <= '0;
         byte_idx   <= '0;
         word_cnt   <= '0;
         chk_q      <= '0;
         ovf_sticky <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid_q    <= in_valid;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;

         if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
         unique case ({push_ok_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push_c && full_c && !pop_c) begin
            overflow   <= 1'b1;
            ovf_sticky <= 1'b1;
         end

         if (byte_stb) begin
            unique case (state)
               S_IDLE: begin
                  if (in_data == SYNC_BYTE) begin
                     state <= S_LEN;
                     busy  <= 1'b1;
                  end
               end
               S_LEN: begin
                  if (in_data == 8'h00) begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                     busy      <= 1'b0;
                  end else begin
                     word_cnt <= in_data;
                     chk_q    <= in_data;
                     byte_idx <= '0;
                     asm_q    <= '0;
                     state    <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  chk_q <= chk_q ^ in_data;
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx <= '0;
                     asm_q    <= '0;
                     word_cnt <= word_cnt - 8'd1;
                     if (word_cnt == 8'd1) state <= S_CHECK;
                  end else begin
                     asm_q    <= word_c;
                     byte_idx <= byte_idx + BW'(1);
                  end
               end
               S_CHECK: begin
                  if ((in_data == chk_q) && !ovf_sticky) frame_done <= 1'b1;
                  else                                   frame_err  <= 1'b1;
                  ovf_sticky <= 1'b0;
                  chk_q      <= '0;
                  state      <= S_IDLE;
                  busy       <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler (default parameters: 16-bit words,
// 8-entry FIFO, SYNC = A5). Stimulus pushes expected words into a queue; a
// monitor pops and compares whenever the DUT hands over a word.
module tb_uart_frame_assembler;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        frame_done;
   logic        frame_err;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0, err_cnt = 0, ovf_cnt = 0;
   int done_base, err_base, ovf_base;
   logic [15:0] exp_q[$];

   uart_frame_assembler dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Monitor: pulse counting and word scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         if (frame_done) done_cnt++;
         if (frame_err)  err_cnt++;
         if (overflow)   ovf_cnt++;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL word_unexpected: got %h, none expected", out_data);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL word_data: got %h expected %h", out_data, e);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic mark();
      done_base = done_cnt;
      err_base  = err_cnt;
      ovf_base  = ovf_cnt;
   endtask

   task automatic pulses(input string name, input int d, input int e, input int o);
      repeat (3) @(posedge clk);
      #1;
      check({name, "_done"}, done_cnt - done_base, d);
      check({name, "_err"},  err_cnt - err_base,   e);
      check({name, "_ovf"},  ovf_cnt - ovf_base,   o);
   endtask

   // Drive one byte: valid high for `hold` edges, then low for one edge.
   // With rp set, out_ready is raised for exactly the edge that takes the byte.
   task automatic send_byte(input logic [7:0] b, input int hold, input bit rp);
      in_data  = b;
      in_valid = 1'b1;
      if (rp) out_ready = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      if (rp) out_ready = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] len, input byte_q_t pl, input bit bad,
                             input int hold, input int exp_words, input bit rp_last);
      logic [7:0] chk;
      chk = len;
      foreach (pl[i]) chk ^= pl[i];
      if (bad) chk ^= 8'h01;
      for (int k = 0; k < exp_words; k++) exp_q.push_back({pl[2*k+1], pl[2*k]});
      send_byte(8'hA5, hold, 1'b0);
      send_byte(len, hold, 1'b0);
      foreach (pl[i]) send_byte(pl[i], hold, rp_last && (i == pl.size() - 1));
      send_byte(chk, hold, 1'b0);
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
      check({name, "_empty"}, int'(out_valid), 0);
   endtask

   initial begin
      byte_q_t pl;
      reset     = 1'b0;
      in_data   = 8'hA5;
      in_valid  = 1'b1;
      out_ready = 1'b0;

      // Reset with valid already high: nothing taken afterwards.
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_pulses", int'({frame_done, frame_err, overflow}), 0);
      check("rst_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_level_valid_busy", int'(busy), 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;

      // Good frame.
      mark();
      pl = '{8'h34, 8'h12, 8'h78, 8'h56};
      send_frame(8'h02, pl, 1'b0, 1, 2, 1'b0);
      pulses("good", 1, 0, 0);
      check("good_words", exp_q.size(), 0);

      // Bad checksum: words still delivered.
      mark();
      send_frame(8'h02, pl, 1'b1, 1, 2, 1'b0);
      pulses("badchk", 0, 1, 0);
      check("badchk_words", exp_q.size(), 0);

      // Noise, then LEN=0, then a good frame.
      mark();
      send_byte(8'h00, 1, 1'b0);
      check("noise_busy0", int'(busy), 0);
      send_byte(8'hFF, 1, 1'b0);
      check("noise_busy1", int'(busy), 0);
      send_byte(8'h5A, 1, 1'b0);
      check("noise_busy2", int'(busy), 0);
      send_byte(8'hA5, 1, 1'b0);
      check("sync_busy", int'(busy), 1);
      send_byte(8'h00, 1, 1'b0);
      check("len0_busy", int'(busy), 0);
      pulses("len0", 0, 1, 0);
      mark();
      send_frame(8'h02, pl, 1'b0, 1, 2, 1'b0);
      pulses("after_len0", 1, 0, 0);

      // Overflow: LEN=10 into 8 entries with no consumer.
      out_ready = 1'b0;
      mark();
      pl = {};
      for (int i = 0; i < 20; i++) pl.push_back(8'(8'h11 * (i % 15) + i));
      send_frame(8'h0A, pl, 1'b0, 1, 8, 1'b0);
      pulses("ovf", 0, 1, 2);
      check("ovf_held_valid", int'(out_valid), 1);
      check("ovf_head", int'(out_data), int'({pl[1], pl[0]}));
      drain("ovf_drain");

      // Level valid held 5 cycles per byte.
      mark();
      pl = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_frame(8'h02, pl, 1'b0, 5, 2, 1'b0);
      pulses("level", 1, 0, 0);
      check("level_words", exp_q.size(), 0);

      // Fill FIFO, then complete a word while full with a pop on the same edge.
      out_ready = 1'b0;
      mark();
      pl = {};
      for (int i = 0; i < 16; i++) pl.push_back(8'(8'h40 + i));
      send_frame(8'h08, pl, 1'b0, 1, 8, 1'b0);
      pl = '{8'hCD, 8'hAB};
      send_frame(8'h01, pl, 1'b0, 1, 1, 1'b1);
      pulses("pushpop", 2, 0, 0);
      check("pushpop_pending", exp_q.size(), 8);
      drain("pushpop_drain");

      // Reset after the third payload byte.
      out_ready = 1'b0;
      send_byte(8'hA5, 1, 1'b0);
      send_byte(8'h02, 1, 1'b0);
      send_byte(8'h34, 1, 1'b0);
      send_byte(8'h12, 1, 1'b0);
      send_byte(8'h78, 1, 1'b0);
      check("midrst_pre_valid", int'(out_valid), 1);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      mark();
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_data", int'(out_data), 0);
      check("midrst_busy", int'(busy), 0);
      pulses("midrst", 0, 0, 0);
      out_ready = 1'b1;
      mark();
      pl = '{8'h34, 8'h12, 8'h78, 8'h56};
      send_frame(8'h02, pl, 1'b0, 1, 2, 1'b0);
      pulses("midrst_next", 1, 0, 0);
      drain("midrst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
